ram_burst_ctrl: RTL and testbench
=================================

Name: ram_burst_ctrl

Overview:
- Burst sequencer directly upstream of the 1K x 8 single-port RAM; owns its wr/addr/data_in and consumes its combinational data_out.
- Accepts one command per burst (direction, start address, length) over a valid/ready handshake.
- Write bursts: streams write data into consecutive RAM locations.
- Read bursts: streams RAM contents out through a registered valid/ready output.

Parameters:
- ADDR_W, 10, RAM address width; burst address space is 2^ADDR_W words.
- DATA_W, 8, RAM data width.
- LEN_W, 10, width of cmd_len; burst length = cmd_len + 1 beats (1..2^LEN_W).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller idle, command accepted on valid&&ready
- cmd_wr  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  burst start address
- cmd_len  in  LEN_W  beats minus one
- wd_valid  in  1  write beat offered
- wd_ready  out  1  write beat accepted on valid&&ready
- wd_data  in  DATA_W  write beat data
- rd_valid  out  1  read beat available
- rd_ready  in  1  downstream accepts read beat
- rd_data  out  DATA_W  read beat data
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at burst completion
- ram_wr  out  1  to RAM wr
- ram_addr  out  ADDR_W  to RAM addr
- ram_wdata  out  DATA_W  to RAM data_in
- ram_rdata  in  DATA_W  from RAM data_out

Behaviour:
- Reset (rst=0, async): state=IDLE; ptr=0; remaining=0; rd_valid=0; rd_data=0; done=0; err=0. Outputs: cmd_ready=1, wd_ready=0, busy=0, ram_wr=0, ram_addr=0, ram_wdata=0.
- Reset asserted mid-burst: burst is abandoned immediately; no further RAM writes; pending read beat is dropped.
- States: IDLE, WRITE, READ, RD_DRAIN.
- IDLE:
  - cmd_ready=1.
  - On cmd accept: ptr<=cmd_addr, remaining<=cmd_len; go to WRITE if cmd_wr=1, else READ.
- WRITE:
  - wd_ready=1, ram_addr=ptr, ram_wdata=wd_data, ram_wr=wd_valid (combinational). RAM commits the beat on the same edge.
  - Per accepted beat: ptr<=ptr+1 mod 2^ADDR_W; remaining<=remaining-1.
  - Last beat accepted (remaining==0): go to IDLE; done=1 on the following cycle.
  - wd_valid=0 stalls without side effects.
- READ:
  - ram_wr=0, ram_addr=ptr; ram_rdata is valid in the same cycle.
  - Capture when !rd_valid || rd_ready: rd_data<=ram_rdata, rd_valid<=1, ptr++, remaining--.
  - Last capture: go to RD_DRAIN.
  - Throughput: 1 beat/cycle with rd_ready held high. Latency: address-to-rd_valid = 1 cycle.
- RD_DRAIN:
  - ram_wr=0.
  - On rd_valid&&rd_ready: rd_valid<=0, done=1 next cycle, go to IDLE.
- rd_valid deasserts only on handshake or reset. rd_data is stable while rd_valid=1 && !rd_ready.
- ram_wr is never high outside WRITE.
- Address wrap: ptr wraps 2^ADDR_W-1 -> 0.
- Full-length burst: cmd_len = 2^LEN_W-1 gives 2^LEN_W beats. With LEN_W=ADDR_W, every location is touched exactly once.
- Commands offered while busy are not accepted (cmd_ready=0). Upstream must hold cmd_valid and fields stable until accepted.

Optional Feature:
- Macro: RAM_BURST_BOUND_CHECK_EN.
- Defined:
  - Adds output err (1 bit).
  - A command with cmd_addr + cmd_len + 1 > 2^ADDR_W is accepted but not executed: state stays IDLE, err and done pulse together for one cycle the cycle after acceptance, and no RAM access occurs.
- Undefined: no err port; bursts wrap around the address space as described above.

Test Plan:
- Write burst addr=0x010, len=3, data A0,A1,A2,A3 with wd_valid held high -> ram_wr high for exactly 4 cycles on addresses 0x010..0x013; done pulses once; busy low after.
- Read burst addr=0x010, len=3, rd_ready=1 -> rd_data A0,A1,A2,A3 on consecutive cycles; first rd_valid 1 cycle after entering READ; done after 4th handshake.
- Read with rd_ready toggled 1,0,0,1,... -> no beat lost or duplicated; rd_data held stable while stalled.
- Wrap write at addr=0x3FE, len=3 -> writes to 0x3FE, 0x3FF, 0x000, 0x001. With RAM_BURST_BOUND_CHECK_EN defined: err=1, no RAM writes.
- rst driven low in the middle of a len=15 write after 5 beats -> all outputs at reset values asynchronously; only 5 locations modified; next command accepted normally.
- Gapped wd_valid (1,0,1,0) with len=1 -> exactly 2 writes; ram_wr low in gap cycles; cmd_valid offered during the burst is not accepted until IDLE.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
// Burst sequencer in front of a single-port RAM: write bursts stream wd_* into consecutive
// locations, read bursts stream RAM words out on rd_*. Define RAM_BURST_BOUND_CHECK_EN to reject wrapping bursts.
module ram_burst_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
`ifdef RAM_BURST_BOUND_CHECK_EN
    output logic              err,
`endif
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    // state    | meaning
    // IDLE     | waiting for a command, cmd_ready high
    // WRITE    | accepting write beats into RAM
    // READ     | capturing RAM words into the rd_* output register
    // RD_DRAIN | last word captured, waiting for its handshake
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        READ     = 2'd2,
        RD_DRAIN = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]  remaining;
    logic              cmd_acc, wr_beat, rd_cap, rd_hs, last, reject;

`ifdef RAM_BURST_BOUND_CHECK_EN
    localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 2;
    logic [SUM_W-1:0] span_end;

    assign span_end = SUM_W'(cmd_addr) + SUM_W'(cmd_len) + SUM_W'(1);
    assign reject   = (span_end > (SUM_W'(1) << ADDR_W));
`else
    assign reject = 1'b0;
`endif

    assign busy     = (state != IDLE);
    assign ram_addr = ptr;
    assign last     = (remaining == '0);
    assign rd_hs    = rd_valid && rd_ready;

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wd_ready  = 1'b0;
        ram_wr    = 1'b0;
        ram_wdata = '0;
        cmd_acc   = 1'b0;
        wr_beat   = 1'b0;
        rd_cap    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                cmd_acc   = cmd_valid;
                if (cmd_valid && !reject)
                    state_nxt = cmd_wr ? WRITE : READ;
            end
            WRITE: begin
                wd_ready  = 1'b1;
                ram_wdata = wd_data;
                ram_wr    = wd_valid;
                wr_beat   = wd_valid;
                if (wd_valid && last)
                    state_nxt = IDLE;
            end
            READ: begin
                // output register is free when empty or being drained this cycle
                rd_cap = !rd_valid || rd_ready;
                if (rd_cap && last)
                    state_nxt = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (rd_hs)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            done      <= 1'b0;
`ifdef RAM_BURST_BOUND_CHECK_EN
            err       <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            done  <= (wr_beat && last) || (state == RD_DRAIN && rd_hs) || (cmd_acc && reject);
`ifdef RAM_BURST_BOUND_CHECK_EN
            err   <= cmd_acc && reject;
`endif
            if (cmd_acc) begin
                ptr       <= cmd_addr;
                remaining <= cmd_len;
            end
            if (wr_beat || rd_cap) begin
                ptr       <= ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (rd_cap) begin
                rd_data  <= ram_rdata;
                rd_valid <= 1'b1;
            end else if (rd_hs) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: table of bursts against a 1K x 8 RAM model and a shadow memory,
// plus a hand-written reset-in-the-middle-of-a-write sequence.
module tb_ram_burst_ctrl;

`ifdef RAM_BURST_BOUND_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_wr;
    logic [9:0] cmd_addr, cmd_len;
    logic       wd_valid, wd_ready;
    logic [7:0] wd_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic       busy, done, err;
    logic       ram_wr;
    logic [9:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;

    logic [7:0] mem     [1024] = '{default: 8'h00};
    logic [7:0] exp_mem [1024] = '{default: 8'h00};

    int checks = 0;
    int errors = 0;

    ram_burst_ctrl #(.ADDR_W(10), .DATA_W(8), .LEN_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
`ifdef RAM_BURST_BOUND_CHECK_EN
        .err       (err),
`endif
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

`ifndef RAM_BURST_BOUND_CHECK_EN
    assign err = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    typedef struct {
        logic       wr;
        logic [9:0] addr;
        logic [9:0] len;
        logic [7:0] dbase;
        logic       gap;
        logic [3:0] rdy_pat;
        logic       hold_cmd;
        logic       oob;
        int         exp_beats;
        int         exp_cycles;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_wd_ready"},  wd_ready,  0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_ram_wr"},    ram_wr,    0);
        chk({tag, "_ram_addr"},  ram_addr,  0);
        chk({tag, "_ram_wdata"}, ram_wdata, 0);
        chk({tag, "_rd_valid"},  rd_valid,  0);
        chk({tag, "_rd_data"},   rd_data,   0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_err"},       err,       0);
    endtask

    task automatic run_vec(input int k);
        vec_t       v = vecs[k];
        int         exp_beats = v.exp_beats;
        int         budget = 4 * v.exp_beats + 16;
        int         beat = 0, cyc = 0, done_cnt = 0, err_cnt = 0, wr_cnt = 0;
        bit         held_v = 1'b0;
        logic [7:0] held_d = 8'h00;
        logic [9:0] a;
        logic [7:0] d;
        if (BC && v.oob) exp_beats = 0;

        @(negedge clk);
        cmd_wr = v.wr; cmd_addr = v.addr; cmd_len = v.len; cmd_valid = 1'b1;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);

        while (beat < exp_beats && cyc < budget) begin
            @(negedge clk);
            if (!v.hold_cmd) cmd_valid = 1'b0;
            a = v.addr + beat[9:0];
            d = 8'(v.dbase + beat);
            if (v.wr) begin
                wd_valid = v.gap ? (cyc % 2 == 0) : 1'b1;
                wd_data  = d;
            end else begin
                rd_ready = v.rdy_pat[cyc % 4];
            end
            #1;
            chk("busy_in_burst", busy, 1);
            chk("cmd_ready_busy", cmd_ready, 0);
            if (done) done_cnt++;
            if (v.wr) begin
                chk("ram_wr_vs_wd_valid", ram_wr, wd_valid);
                if (ram_wr) begin
                    wr_cnt++;
                    chk("wr_addr", ram_addr, a);
                    chk("wr_data", ram_wdata, d);
                    exp_mem[a] = d;
                    beat++;
                end
            end else begin
                if (cyc == 0) chk("rd_valid_first_cycle", rd_valid, 0);
                if (cyc == 1) chk("rd_valid_second_cycle", rd_valid, 1);
                if (held_v) begin
                    chk("rd_hold_valid", rd_valid, 1);
                    chk("rd_hold_data", rd_data, held_d);
                end
                if (rd_valid && rd_ready) begin
                    chk("rd_data", rd_data, exp_mem[a]);
                    beat++;
                end
                held_v = rd_valid && !rd_ready;
                held_d = rd_data;
            end
            cyc++;
        end

        chk("beats", beat, exp_beats);
        chk("burst_cycles", cyc, (BC && v.oob) ? 0 : v.exp_cycles);

        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            cmd_valid = 1'b0; wd_valid = 1'b0; rd_ready = 1'b0;
            #1;
            if (p == 0) chk("done_after_burst", done, 1);
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (ram_wr) wr_cnt++;
            chk("busy_after", busy, 0);
            chk("rd_valid_after", rd_valid, 0);
        end
        chk("done_count", done_cnt, 1);
        chk("write_count", wr_cnt, v.wr ? exp_beats : 0);
        chk("err_count", err_cnt, (BC && v.oob) ? 1 : 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz;
        //            wr    addr     len       dbase  gap   rdy    hold  oob  beats cycles
        vecs[0]  = '{1'b1, 10'h010, 10'd3,    8'hA0, 1'b0, 4'hF, 1'b0, 1'b0, 4,    4};
        vecs[1]  = '{1'b0, 10'h010, 10'd3,    8'h00, 1'b0, 4'hF, 1'b0, 1'b0, 4,    5};
        vecs[2]  = '{1'b0, 10'h010, 10'd3,    8'h00, 1'b0, 4'h9, 1'b0, 1'b0, 4,    9};
        vecs[3]  = '{1'b1, 10'h3FE, 10'd3,    8'hC0, 1'b0, 4'hF, 1'b0, 1'b1, 4,    4};
        vecs[4]  = '{1'b0, 10'h3FE, 10'd3,    8'h00, 1'b0, 4'hF, 1'b0, 1'b1, 4,    5};
        vecs[5]  = '{1'b1, 10'h200, 10'd1,    8'h33, 1'b1, 4'hF, 1'b1, 1'b0, 2,    3};
        vecs[6]  = '{1'b0, 10'h200, 10'd1,    8'h00, 1'b0, 4'hA, 1'b0, 1'b0, 2,    4};
        vecs[7]  = '{1'b0, 10'h100, 10'd4,    8'h00, 1'b0, 4'hF, 1'b0, 1'b0, 5,    6};
        vecs[8]  = '{1'b1, 10'h3FF, 10'd0,    8'h77, 1'b0, 4'hF, 1'b0, 1'b0, 1,    1};
        vecs[9]  = '{1'b0, 10'h3FF, 10'd0,    8'h00, 1'b0, 4'h6, 1'b0, 1'b0, 1,    2};
        vecs[10] = '{1'b1, 10'h000, 10'h3FF,  8'h00, 1'b0, 4'hF, 1'b0, 1'b0, 1024, 1024};
        vecs[11] = '{1'b0, 10'h000, 10'h3FF,  8'h00, 1'b0, 4'hF, 1'b0, 1'b0, 1024, 1025};

        rst = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // reset pulled after 5 beats of a 16-beat write
        @(negedge clk);
        cmd_wr = 1'b1; cmd_addr = 10'h100; cmd_len = 10'd15; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0; wd_valid = 1'b1; wd_data = 8'(8'h50 + i);
            #1;
            chk("rst_seq_ram_wr", ram_wr, 1);
            chk("rst_seq_addr", ram_addr, 10'h100 + 10'(i));
            exp_mem[10'h100 + 10'(i)] = 8'(8'h50 + i);
        end
        @(negedge clk);
        wd_data = 8'h55;
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("mid_burst_reset");
        repeat (2) @(posedge clk);
        #1;
        chk("rst_held_ram_wr", ram_wr, 0);
        nz = 0;
        for (int i = 0; i < 16; i++) begin
            if (mem[10'h100 + 10'(i)] != 8'h00) nz++;
        end
        chk("rst_seq_locations_written", nz, 5);
        @(negedge clk);
        wd_valid = 1'b0;
        rst = 1'b1;

        for (int k = 0; k < 12; k++) run_vec(k);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
